// File: rtl/seq_lock_pkg.sv
// seq_lock_pkg
//   Shared definitions for the parametrised sequential lock.
//   - state_t       : FSM state encoding (ENTER..LOCKOUT), codes 6-7 unused
//   - DEF_*         : default values for the lock parameters
//   - codeDigit()   : extracts digit idx from a packed code word
package seq_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTER   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_ERROR   = 3'd3,
    ST_PROG    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  localparam int          DEF_NUM_DIGITS     = 6;
  localparam int          DEF_DIGIT_W        = 4;
  localparam int          DEF_MAX_DIGIT      = 9;
  localparam logic [23:0] DEF_CODE           = 24'h137234;
  localparam int          DEF_MAX_FAIL       = 3;
  localparam int          DEF_LOCKOUT_CYCLES = 16;

  // Widest code / digit the helper can handle; callers widen their code
  // word to MAX_CODE_W and truncate the result back to their digit width.
  localparam int MAX_CODE_W  = 64;
  localparam int MAX_DIGIT_W = 16;

  // Digit idx of a code whose digit i lives at [i*digitW +: digitW].
  function automatic logic [MAX_DIGIT_W-1:0] codeDigit(
    input logic [MAX_CODE_W-1:0] code,
    input int                    idx,
    input int                    digitW
  );
    logic [MAX_CODE_W-1:0] mask;
    mask = (MAX_CODE_W'(1) << digitW) - MAX_CODE_W'(1);
    return MAX_DIGIT_W'((code >> (idx * digitW)) & mask);
  endfunction

endpackage

// File: rtl/seq_lock_param_if.sv
// seq_lock_param_if
//   Bundles the keypad-side controls and the display-side status of the lock.
//   Inputs to the lock : digit_valid, digit, prog_en, relock, clear
//   Outputs of the lock: present_state, open, closed, error, locked_out,
//                        digit_idx, fail_cnt
//   master modport = the driver of the keypad side, slave = the lock itself.
interface seq_lock_param_if #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 4,
  parameter int MAX_FAIL   = 3
);
  localparam int IDX_W  = $clog2(NUM_DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               prog_en;
  logic               relock;
  logic               clear;

  logic [2:0]         present_state;
  logic               open;
  logic               closed;
  logic               error;
  logic               locked_out;
  logic [IDX_W-1:0]   digit_idx;
  logic [FAIL_W-1:0]  fail_cnt;

  modport master (
    output digit_valid, digit, prog_en, relock, clear,
    input  present_state, open, closed, error, locked_out, digit_idx, fail_cnt
  );

  modport slave (
    input  digit_valid, digit, prog_en, relock, clear,
    output present_state, open, closed, error, locked_out, digit_idx, fail_cnt
  );
endinterface

// File: rtl/lockout_timer.sv
// lockout_timer
//   Down-counter that times the lockout period.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (count -> 0)
//   i_load : load CYCLES-1 this edge
//   o_done : count has reached 0
module lockout_timer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_done
);
  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Loading CYCLES-1 gives exactly CYCLES cycles with the count visible
  // before o_done lets the lock leave on the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(CYCLES - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_done = (r_count == '0);
endmodule

// File: rtl/seq_lock_param.sv
// seq_lock_param
//   Programmable digit-sequence lock with failure counting and timed lockout.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : seq_lock_param_if.slave (keypad controls in, display status out)
module seq_lock_param
  import seq_lock_pkg::*;
#(
  parameter int                               NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int                               DIGIT_W        = DEF_DIGIT_W,
  parameter int                               MAX_DIGIT      = DEF_MAX_DIGIT,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]    DEFAULT_CODE   = DEF_CODE,
  parameter int                               MAX_FAIL       = DEF_MAX_FAIL,
  parameter int                               LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input logic             clk,
  input logic             reset,
  seq_lock_param_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int CODE_W = NUM_DIGITS * DIGIT_W;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FAIL_W-1:0]  FAIL_SAT  = FAIL_W'(MAX_FAIL);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(MAX_DIGIT);

  state_t              r_state,     w_stateNext;
  logic [IDX_W-1:0]    r_digitIdx,  w_digitIdxNext;
  logic [FAIL_W-1:0]   r_failCnt,   w_failCntNext;
  logic                r_mismatch,  w_mismatchNext;
  logic [CODE_W-1:0]   r_code,      w_codeNext;
  logic [CODE_W-1:0]   r_shadow,    w_shadowNext;

  logic                w_digitBad;
  logic [DIGIT_W-1:0]  w_codeDigit;
  logic [FAIL_W-1:0]   w_failInc;
  logic [CODE_W-1:0]   w_shadowWr;
  logic                w_anyMismatch;
  logic                w_timerLoad;
  logic                w_timerDone;

  assign w_digitBad  = (bus.digit > DIGIT_MAX);
  assign w_codeDigit = DIGIT_W'(codeDigit(MAX_CODE_W'(r_code), int'(r_digitIdx), DIGIT_W));
  assign w_failInc   = (r_failCnt == FAIL_SAT) ? r_failCnt : r_failCnt + FAIL_W'(1);

  lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_timerLoad),
    .o_done (w_timerDone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ENTER;
      r_digitIdx <= '0;
      r_failCnt  <= '0;
      r_mismatch <= 1'b0;
      r_code     <= DEFAULT_CODE;
      r_shadow   <= DEFAULT_CODE;
    end else begin
      r_state    <= w_stateNext;
      r_digitIdx <= w_digitIdxNext;
      r_failCnt  <= w_failCntNext;
      r_mismatch <= w_mismatchNext;
      r_code     <= w_codeNext;
      r_shadow   <= w_shadowNext;
    end
  end

  // Programming edits a shadow copy; the live code only changes when the
  // last digit lands, so an aborted pass leaves the old code intact.
  // The mismatch flag is sticky over the whole entry so the wrong
  // position is never revealed by an early exit.
  always_comb begin
    w_stateNext    = r_state;
    w_digitIdxNext = r_digitIdx;
    w_failCntNext  = r_failCnt;
    w_mismatchNext = r_mismatch;
    w_codeNext     = r_code;
    w_shadowNext   = r_shadow;
    w_timerLoad    = 1'b0;

    w_shadowWr = (r_state == ST_OPEN) ? r_code : r_shadow;
    w_shadowWr[int'(r_digitIdx)*DIGIT_W +: DIGIT_W] = bus.digit;
    w_anyMismatch = r_mismatch | (bus.digit != w_codeDigit);

    case (r_state)
      ST_ENTER: begin
        if (bus.digit_valid) begin
          if (w_digitBad) begin
            w_stateNext    = ST_ERROR;
            w_failCntNext  = w_failInc;
            w_digitIdxNext = '0;
            w_mismatchNext = 1'b0;
          end else if (r_digitIdx == LAST_IDX) begin
            w_digitIdxNext = '0;
            w_mismatchNext = 1'b0;
            if (w_anyMismatch) begin
              w_stateNext   = ST_CLOSED;
              w_failCntNext = w_failInc;
            end else begin
              w_stateNext   = ST_OPEN;
              w_failCntNext = '0;
            end
          end else begin
            w_digitIdxNext = r_digitIdx + IDX_W'(1);
            w_mismatchNext = w_anyMismatch;
          end
        end
      end

      ST_OPEN, ST_PROG: begin
        if ((r_state == ST_OPEN) && bus.relock) begin
          w_stateNext = ST_ENTER;
        end else if (bus.digit_valid && (r_state == ST_PROG || bus.prog_en)) begin
          if (w_digitBad) begin
            w_stateNext    = ST_ERROR;
            w_digitIdxNext = '0;
          end else if (r_digitIdx == LAST_IDX) begin
            w_stateNext    = ST_OPEN;
            w_codeNext     = w_shadowWr;
            w_shadowNext   = w_shadowWr;
            w_digitIdxNext = '0;
          end else begin
            w_stateNext    = ST_PROG;
            w_shadowNext   = w_shadowWr;
            w_digitIdxNext = r_digitIdx + IDX_W'(1);
          end
        end
      end

      ST_CLOSED, ST_ERROR: begin
        if (bus.clear) begin
          if (r_failCnt == FAIL_SAT) begin
            w_stateNext = ST_LOCKOUT;
            w_timerLoad = 1'b1;
          end else begin
            w_stateNext = ST_ENTER;
          end
        end
      end

      ST_LOCKOUT: begin
        if (w_timerDone) begin
          w_stateNext   = ST_ENTER;
          w_failCntNext = '0;
        end
      end

      default: begin
        w_stateNext    = ST_ENTER;
        w_digitIdxNext = '0;
        w_mismatchNext = 1'b0;
      end
    endcase
  end

  assign bus.present_state = r_state;
  assign bus.open          = (r_state == ST_OPEN);
  assign bus.closed        = (r_state == ST_CLOSED);
  assign bus.error         = (r_state == ST_ERROR);
  assign bus.locked_out    = (r_state == ST_LOCKOUT);
  assign bus.digit_idx     = r_digitIdx;
  assign bus.fail_cnt      = r_failCnt;
endmodule
